// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory (slave).
// Signal names keep the original stage-side port names for drop-in compatibility.
interface mem_access_stage_if #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned DMEM_ADDR_WIDTH = 8
);
    logic                       dmem_req_o;
    logic                       dmem_we_o;
    logic [DMEM_ADDR_WIDTH-1:0] dmem_addr_o;
    logic [DATA_WIDTH-1:0]      dmem_wdata_o;
    logic [DATA_WIDTH-1:0]      dmem_rdata_i;
    logic                       dmem_ack_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_rdata_i, dmem_ack_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output dmem_rdata_i, dmem_ack_i
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage pipeline: 64-bit loads/stores over a variable-latency
// req/ack data memory, stalling upstream while an access is outstanding.
module mem_access_stage #(
    parameter int unsigned DATA_WIDTH            = 64,
    parameter int unsigned REGFILE_ADDRESS_WIDTH = 5,
    parameter int unsigned DMEM_ADDR_WIDTH       = 8,
    parameter int unsigned TIMEOUT_CYCLES        = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             valid_i,
    input  logic [DATA_WIDTH-1:0]            aluResult_i,
    input  logic [DATA_WIDTH-1:0]            storeData_i,
    input  logic                             memRead_i,
    input  logic                             memWrite_i,
    input  logic                             mem2Reg_i,
    input  logic                             regWrite_i,
    input  logic [REGFILE_ADDRESS_WIDTH-1:0] writeReg_i,
    mem_access_stage_if.master               dmem,
    output logic [DATA_WIDTH-1:0]            memRead_dataOut_o,
    output logic [DATA_WIDTH-1:0]            regData_o,
    output logic                             mem2Reg_o,
    output logic                             regWrite_o,
    output logic [REGFILE_ADDRESS_WIDTH-1:0] writeReg_o,
    output logic                             stall_o,
    output logic                             bus_err_o,
    output logic                             misalign_o
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                state;
    state_t                state_next;
    logic [7:0]            req_cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  is_mem;
    logic                  access;
    logic                  req;
    logic                  timeout;

    assign is_mem  = valid_i & (memRead_i | memWrite_i);
    assign access  = is_mem & (aluResult_i[2:0] == 3'b000);
    assign timeout = (state == WAIT) & ~dmem.dmem_ack_i & (req_cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (access) state_next = dmem.dmem_ack_i ? DONE : WAIT;
            WAIT:    if (dmem.dmem_ack_i || timeout) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request is gated by reset so it drops the instant reset asserts, even
    // while the upstream register still presents the interrupted access.
    always_comb begin
        req = 1'b0;
        case (state)
            IDLE:    req = access;
            WAIT:    req = 1'b1;
            default: req = 1'b0;
        endcase
        req = req & reset;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_cnt <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && state_next == WAIT) req_cnt <= '0;
            else if (state == WAIT)                  req_cnt <= req_cnt + 8'd1;

            if (req && dmem.dmem_ack_i && !memWrite_i) rdata_q <= dmem.dmem_rdata_i;
            else if (timeout)                          rdata_q <= '0;

            if (timeout)            err_q <= 1'b1;
            else if (state == DONE) err_q <= 1'b0;
        end
    end

    assign dmem.dmem_req_o   = req;
    assign dmem.dmem_we_o    = req & memWrite_i;
    assign dmem.dmem_addr_o  = aluResult_i[DMEM_ADDR_WIDTH+2:3];
    assign dmem.dmem_wdata_o = storeData_i;

    assign stall_o           = req;
    assign bus_err_o         = (state == DONE) & err_q;
    assign misalign_o        = is_mem & (aluResult_i[2:0] != 3'b000);
    assign memRead_dataOut_o = rdata_q;
    assign regData_o         = aluResult_i;
    assign mem2Reg_o         = mem2Reg_i;
    assign writeReg_o        = writeReg_i;
    assign regWrite_o        = regWrite_i & valid_i & ~misalign_o & ~bus_err_o;
endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed cases plus randomized instructions
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_access_stage;
    localparam int unsigned DW = 64;
    localparam int unsigned RW = 5;
    localparam int unsigned AW = 8;
    localparam int unsigned TO = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          valid_i = 1'b0;
    logic [DW-1:0] aluResult_i = '0;
    logic [DW-1:0] storeData_i = '0;
    logic          memRead_i = 1'b0;
    logic          memWrite_i = 1'b0;
    logic          mem2Reg_i = 1'b0;
    logic          regWrite_i = 1'b0;
    logic [RW-1:0] writeReg_i = '0;
    logic [DW-1:0] memRead_dataOut_o;
    logic [DW-1:0] regData_o;
    logic          mem2Reg_o;
    logic          regWrite_o;
    logic [RW-1:0] writeReg_o;
    logic          stall_o;
    logic          bus_err_o;
    logic          misalign_o;

    int unsigned   total = 0;
    int unsigned   bad = 0;
    logic [DW-1:0] model_rdata = '0;

    mem_access_stage_if #(.DATA_WIDTH(DW), .DMEM_ADDR_WIDTH(AW)) dmem_bus ();

    mem_access_stage #(
        .DATA_WIDTH(DW), .REGFILE_ADDRESS_WIDTH(RW),
        .DMEM_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .valid_i(valid_i),
        .aluResult_i(aluResult_i), .storeData_i(storeData_i),
        .memRead_i(memRead_i), .memWrite_i(memWrite_i),
        .mem2Reg_i(mem2Reg_i), .regWrite_i(regWrite_i), .writeReg_i(writeReg_i),
        .dmem(dmem_bus),
        .memRead_dataOut_o(memRead_dataOut_o), .regData_o(regData_o),
        .mem2Reg_o(mem2Reg_o), .regWrite_o(regWrite_o), .writeReg_o(writeReg_o),
        .stall_o(stall_o), .bus_err_o(bus_err_o), .misalign_o(misalign_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // One instruction held in the stage; memory acks n cycles after the first request cycle.
    task automatic run_instr(input logic v, input logic rd, input logic wr, input logic m2r,
                             input logic rw, input logic [DW-1:0] alu, input logic [DW-1:0] sd,
                             input logic [RW-1:0] wreg, input int unsigned n,
                             input logic [DW-1:0] rdat);
        logic        acc, mis, tmo, req_e, done_c;
        int unsigned reqc, tot;
        acc  = v & (rd | wr) & (alu[2:0] == 3'b000);
        mis  = v & (rd | wr) & (alu[2:0] != 3'b000);
        tmo  = acc && (n > TO);
        reqc = acc ? (tmo ? TO + 1 : n + 1) : 0;
        tot  = acc ? reqc + 1 : 1;
        for (int unsigned c = 0; c < tot; c++) begin
            @(negedge clock);
            valid_i = v; memRead_i = rd; memWrite_i = wr; mem2Reg_i = m2r;
            regWrite_i = rw; aluResult_i = alu; storeData_i = sd; writeReg_i = wreg;
            if (acc) begin
                dmem_bus.dmem_ack_i   = (c == n);
                dmem_bus.dmem_rdata_i = (c == n) ? rdat : {$urandom, $urandom};
            end else begin
                dmem_bus.dmem_ack_i   = 1'($urandom_range(0, 1));
                dmem_bus.dmem_rdata_i = {$urandom, $urandom};
            end
            done_c = acc && (c == reqc);
            if (done_c) model_rdata = tmo ? '0 : (!wr ? rdat : model_rdata);
            req_e = acc && (c < reqc);
            #1;
            check("req", dmem_bus.dmem_req_o, req_e);
            check("stall", stall_o, req_e);
            check("we", dmem_bus.dmem_we_o, req_e & wr);
            if (req_e) begin
                check("addr", dmem_bus.dmem_addr_o, alu[AW+2:3]);
                check("wdata", dmem_bus.dmem_wdata_o, sd);
            end
            check("misalign", misalign_o, mis);
            check("regwrite", regWrite_o, rw & v & ~mis & ~(tmo & done_c));
            check("bus_err", bus_err_o, tmo & done_c);
            check("rdata_out", memRead_dataOut_o, model_rdata);
            check("regdata", regData_o, alu);
            check("writereg", writeReg_o, wreg);
            check("mem2reg", mem2Reg_o, m2r);
        end
    endtask

    initial begin
        logic          rv, rr, rwr;
        logic [DW-1:0] ralu;
        int unsigned   kind;
        dmem_bus.dmem_ack_i   = 1'b0;
        dmem_bus.dmem_rdata_i = '0;
        // Reset with an aligned load presented: request must stay low.
        valid_i = 1'b1; memRead_i = 1'b1; aluResult_i = 64'h40; regWrite_i = 1'b1;
        #12;
        check("rst_req", dmem_bus.dmem_req_o, 1'b0);
        check("rst_stall", stall_o, 1'b0);
        check("rst_we", dmem_bus.dmem_we_o, 1'b0);
        check("rst_bus_err", bus_err_o, 1'b0);
        check("rst_rdata", memRead_dataOut_o, '0);
        check("rst_regwrite", regWrite_o, 1'b1);
        @(negedge clock);
        valid_i = 1'b0;
        reset = 1'b1;

        run_instr(1, 1, 0, 1, 1, 64'h40, 64'h0, 5'd7, 3, 64'hDEADBEEF_CAFEF00D);
        run_instr(1, 0, 1, 0, 0, 64'h18, 64'h1234, 5'd0, 0, 64'h0);
        for (int unsigned i = 1; i <= 3; i++)
            run_instr(1, 0, 0, 0, 1, {$urandom, $urandom}, 64'h0, 5'(i), 0, 64'h0);
        run_instr(1, 1, 0, 1, 1, 64'h80, 64'h0, 5'd9, 10, 64'h1111);
        run_instr(1, 1, 0, 1, 1, 64'h41, 64'h0, 5'd4, 0, 64'h2222);
        run_instr(1, 1, 0, 1, 1, 64'h48, 64'h0, 5'd5, 1, 64'h0123_4567_89AB_CDEF);

        // Reset in WAIT, then a late ack two cycles after release with a bubble in the stage.
        @(negedge clock);
        valid_i = 1'b1; memRead_i = 1'b1; memWrite_i = 1'b0; aluResult_i = 64'h100;
        regWrite_i = 1'b1; dmem_bus.dmem_ack_i = 1'b0;
        @(negedge clock);
        #1;
        check("wait_req", dmem_bus.dmem_req_o, 1'b1);
        reset = 1'b0;
        model_rdata = '0;
        #1;
        check("midrst_req", dmem_bus.dmem_req_o, 1'b0);
        check("midrst_stall", stall_o, 1'b0);
        check("midrst_rdata", memRead_dataOut_o, '0);
        check("midrst_bus_err", bus_err_o, 1'b0);
        @(negedge clock);
        valid_i = 1'b0; reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        dmem_bus.dmem_ack_i = 1'b1; dmem_bus.dmem_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        check("late_ack_req", dmem_bus.dmem_req_o, 1'b0);
        @(negedge clock);
        dmem_bus.dmem_ack_i = 1'b0;
        #1;
        check("late_ack_rdata", memRead_dataOut_o, '0);
        check("late_ack_stall", stall_o, 1'b0);
        run_instr(1, 1, 0, 1, 1, 64'h200, 64'h0, 5'd3, 2, 64'h5555_AAAA_5555_AAAA);

        for (int unsigned i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 9);
            rv   = (kind != 0);
            rr   = (kind == 0) ? 1'($urandom_range(0, 1)) : (kind <= 4);
            rwr  = (kind == 5) || (kind == 6) || (kind == 7);
            if (kind == 7) rr = 1'b1;
            ralu = {$urandom, $urandom};
            if ($urandom_range(0, 5) != 0) ralu[2:0] = 3'b000;
            run_instr(rv, rr, rwr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ralu,
                      {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                      $urandom_range(0, TO + 2), {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
